// File: rtl/n_set_cache_miss_handler.sv
// Miss-service sequencer: owns valid/dirty/tag metadata, obtains a victim, writes back, fills, retires.
// Optional N_SET_MISS_INVALID_FIRST_EN: pick the lowest invalid way of the set without asking the policy.
module n_set_cache_miss_handler #(
  parameter int CACHE_BLOCK_CAPACITY = 128,
  parameter int CACHE_SET_SIZE       = 4,
  parameter int BW_BLOCK_ADDR        = 26,
  localparam int BW_CACHE_CAPACITY   = $clog2(CACHE_BLOCK_CAPACITY),
  localparam int BW_GRP              = $clog2(CACHE_SET_SIZE),
  localparam int BW_SET              = BW_CACHE_CAPACITY - BW_GRP,
  localparam int BW_TAG              = BW_BLOCK_ADDR - BW_SET
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         miss_i,
  input  logic                         write_miss_i,
  input  logic [BW_BLOCK_ADDR-1:0]     miss_baddr_i,
  input  logic                         hit_i,
  input  logic                         write_i,
  input  logic [BW_CACHE_CAPACITY-1:0] hit_addr_i,
  input  logic [BW_CACHE_CAPACITY-1:0] meta_addr_i,
  output logic                         meta_valid_o,
  output logic                         meta_dirty_o,
  output logic [BW_TAG-1:0]            meta_tag_o,
  output logic                         pol_miss_o,
  output logic [BW_CACHE_CAPACITY-1:0] pol_addr_o,
  input  logic                         pol_done_i,
  input  logic [BW_CACHE_CAPACITY-1:0] pol_addr_i,
  output logic                         wb_req_o,
  output logic [BW_BLOCK_ADDR-1:0]     wb_baddr_o,
  output logic [BW_CACHE_CAPACITY-1:0] wb_cache_addr_o,
  input  logic                         wb_ack_i,
  output logic                         fill_req_o,
  output logic [BW_BLOCK_ADDR-1:0]     fill_baddr_o,
  output logic [BW_CACHE_CAPACITY-1:0] fill_cache_addr_o,
  input  logic                         fill_ack_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic [BW_CACHE_CAPACITY-1:0] done_addr_o
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_POL, VICTIM, WRITEBACK, FILL, UPDATE, DONE} state_t;

  state_t                         state;
  logic [CACHE_BLOCK_CAPACITY-1:0] valid, dirty;
  logic [BW_TAG-1:0]              tag_mem [CACHE_BLOCK_CAPACITY];
  logic [BW_BLOCK_ADDR-1:0]       cap_baddr;
  logic                           cap_write;
  logic [BW_CACHE_CAPACITY-1:0]   victim;
  logic [BW_CACHE_CAPACITY-1:0]   in_set_addr;
  logic [BW_BLOCK_ADDR-1:0]       victim_baddr;

  // With one set the set field vanishes and the tag is the whole block address.
  generate
    if (BW_SET > 0) begin : g_set
      assign in_set_addr  = BW_CACHE_CAPACITY'(miss_baddr_i[BW_SET-1:0]);
      assign victim_baddr = {tag_mem[victim], victim[BW_SET-1:0]};
    end else begin : g_noset
      assign in_set_addr  = '0;
      assign victim_baddr = tag_mem[victim];
    end
  endgenerate

`ifdef N_SET_MISS_INVALID_FIRST_EN
  logic                         in_inv_found, inv_found_q;
  logic [BW_CACHE_CAPACITY-1:0] in_inv_addr, inv_addr_q;

  // Descending scan so the lowest-index invalid way is the one left standing.
  always_comb begin
    in_inv_found = 1'b0;
    in_inv_addr  = '0;
    for (int g = CACHE_SET_SIZE - 1; g >= 0; g--) begin
      if (!valid[in_set_addr | (BW_CACHE_CAPACITY'(g) << BW_SET)]) begin
        in_inv_found = 1'b1;
        in_inv_addr  = in_set_addr | (BW_CACHE_CAPACITY'(g) << BW_SET);
      end
    end
  end
`endif

  assign busy_o       = (state != IDLE);
  assign meta_valid_o = valid[meta_addr_i];
  assign meta_dirty_o = dirty[meta_addr_i];
  assign meta_tag_o   = tag_mem[meta_addr_i];

  always_ff @(posedge clock_i) begin
    if (state == UPDATE) tag_mem[victim] <= cap_baddr[BW_BLOCK_ADDR-1:BW_SET];
  end

  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state             <= IDLE;
      valid             <= '0;
      dirty             <= '0;
      cap_baddr         <= '0;
      cap_write         <= 1'b0;
      victim            <= '0;
      pol_miss_o        <= 1'b0;
      pol_addr_o        <= '0;
      wb_req_o          <= 1'b0;
      wb_baddr_o        <= '0;
      wb_cache_addr_o   <= '0;
      fill_req_o        <= 1'b0;
      fill_baddr_o      <= '0;
      fill_cache_addr_o <= '0;
      done_o            <= 1'b0;
      done_addr_o       <= '0;
`ifdef N_SET_MISS_INVALID_FIRST_EN
      inv_found_q       <= 1'b0;
      inv_addr_q        <= '0;
`endif
    end else begin
      pol_miss_o <= 1'b0;
      done_o     <= 1'b0;
      // Write hits land first so a same-cycle writeback clear overrides them.
      if (hit_i && write_i) dirty[hit_addr_i] <= 1'b1;
      case (state)
        IDLE: if (miss_i) begin
          cap_baddr  <= miss_baddr_i;
          cap_write  <= write_miss_i;
          pol_addr_o <= in_set_addr;
`ifdef N_SET_MISS_INVALID_FIRST_EN
          inv_found_q <= in_inv_found;
          inv_addr_q  <= in_inv_addr;
          pol_miss_o  <= !in_inv_found;
`else
          pol_miss_o  <= 1'b1;
`endif
          state <= ISSUE;
        end
        ISSUE: begin
`ifdef N_SET_MISS_INVALID_FIRST_EN
          if (inv_found_q) begin
            victim <= inv_addr_q;
            state  <= VICTIM;
          end else
`endif
          state <= WAIT_POL;
        end
        WAIT_POL: if (pol_done_i) begin
          victim <= pol_addr_i;
          state  <= VICTIM;
        end
        VICTIM: begin
          if (valid[victim] && dirty[victim]) begin
            wb_req_o        <= 1'b1;
            wb_baddr_o      <= victim_baddr;
            wb_cache_addr_o <= victim;
            state           <= WRITEBACK;
          end else begin
            fill_req_o        <= 1'b1;
            fill_baddr_o      <= cap_baddr;
            fill_cache_addr_o <= victim;
            state             <= FILL;
          end
        end
        WRITEBACK: if (wb_ack_i) begin
          wb_req_o          <= 1'b0;
          dirty[victim]     <= 1'b0;
          fill_req_o        <= 1'b1;
          fill_baddr_o      <= cap_baddr;
          fill_cache_addr_o <= victim;
          state             <= FILL;
        end
        FILL: if (fill_ack_i) begin
          fill_req_o <= 1'b0;
          state      <= UPDATE;
        end
        UPDATE: begin
          valid[victim] <= 1'b1;
          dirty[victim] <= cap_write;
          done_o        <= 1'b1;
          done_addr_o   <= victim;
          state         <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
